nios_system_led_ctrl: RTL and testbench

- Parametrised Avalon-MM slave output port: the next-generation LED/GPIO output driver for the Nios system.
- Keeps the DATA / OUTSET / OUTCLEAR register model of the existing output PIO.
- Adds per-bit blink mode driven by a programmable prescaler, plus a shared-timer one-shot pulse facility.
- Sits on the system interconnect; out_port drives board LEDs directly.

---
 rtl/nios_system_led_ctrl_if.sv | 14 +
 rtl/nios_system_led_ctrl.sv | 133 +++++++++++++
 tb/tb_nios_system_led_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/nios_system_led_ctrl_if.sv
// Avalon-MM slave bus bundle for the LED/GPIO output controller.
interface nios_system_led_ctrl_if;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_system_led_ctrl.sv
// LED/GPIO output port: DATA/OUTSET/OUTCLEAR registers, per-bit blink from a
// programmable prescaler, and a one-shot pulse timed by the same prescaler.
module nios_system_led_ctrl #(
  parameter int unsigned            WIDTH          = 8,
  parameter int unsigned            PRESCALE_W     = 24,
  parameter logic [WIDTH-1:0]       RESET_VALUE    = '0,
  parameter logic [PRESCALE_W-1:0]  DEFAULT_PERIOD = PRESCALE_W'(24'd4999999)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios_system_led_ctrl_if.slave avs,
  output logic [WIDTH-1:0]     out_port
);

  localparam int unsigned PLEN_W = 8;
  localparam int unsigned BUS_W  = 32;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_PULSE    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_PLEN     = 3'd6;

  logic [WIDTH-1:0]      data;
  logic [WIDTH-1:0]      mode;
  logic [PRESCALE_W-1:0] period;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic                  phase;
  logic [WIDTH-1:0]      pulse_active;
  logic [PLEN_W-1:0]     pulse_cnt;
  logic [PLEN_W-1:0]     pulse_len;

  logic                  wr_c;
  logic                  period_wr_c;
  logic                  pulse_wr_c;
  logic                  tick_c;
  logic [WIDTH-1:0]      wd_w_c;
  logic [PRESCALE_W-1:0] wd_p_c;
  logic [PLEN_W-1:0]     wd_l_c;
  logic                  unused_wd;

  // Bus decode; a PERIOD write suppresses the tick of its own cycle
  always_comb begin
    wr_c        = avs.chipselect && !avs.write_n;
    wd_w_c      = avs.writedata[WIDTH-1:0];
    wd_p_c      = avs.writedata[PRESCALE_W-1:0];
    wd_l_c      = avs.writedata[PLEN_W-1:0];
    period_wr_c = wr_c && (avs.address == ADDR_PERIOD);
    pulse_wr_c  = wr_c && (avs.address == ADDR_PULSE) && (wd_w_c != '0);
    tick_c      = (presc_cnt == '0) && !period_wr_c;
  end

  assign unused_wd = ^avs.writedata;

  // Programmable registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= RESET_VALUE;
      mode      <= '0;
      period    <= DEFAULT_PERIOD;
      pulse_len <= PLEN_W'(1);
    end else if (wr_c) begin
      case (avs.address)
        ADDR_DATA:     data      <= wd_w_c;
        ADDR_MODE:     mode      <= wd_w_c;
        ADDR_PERIOD:   period    <= wd_p_c;
        ADDR_OUTSET:   data      <= data | wd_w_c;
        ADDR_OUTCLEAR: data      <= data & ~wd_w_c;
        ADDR_PLEN:     pulse_len <= wd_l_c;
        default: ;
      endcase
    end
  end

  // Prescaler and blink phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= DEFAULT_PERIOD;
      phase     <= 1'b1;
    end else begin
      if (period_wr_c)
        presc_cnt <= wd_p_c;
      else if (presc_cnt == '0)
        presc_cnt <= period;
      else
        presc_cnt <= presc_cnt - PRESCALE_W'(1);
      if (tick_c)
        phase <= ~phase;
    end
  end

  // One-shot pulse; a PULSE write wins over a coincident tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_active <= '0;
      pulse_cnt    <= '0;
    end else if (pulse_wr_c) begin
      pulse_active <= pulse_active | wd_w_c;
      pulse_cnt    <= (pulse_len == '0) ? PLEN_W'(1) : pulse_len;
    end else if (tick_c && (pulse_active != '0)) begin
      if (pulse_cnt <= PLEN_W'(1)) begin
        pulse_active <= '0;
        pulse_cnt    <= '0;
      end else begin
        pulse_cnt <= pulse_cnt - PLEN_W'(1);
      end
    end
  end

  // Registered LED drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      out_port <= RESET_VALUE;
    else
      out_port <= pulse_active | (data & ~mode) | (data & mode & {WIDTH{phase}});
  end

  // Zero-latency read mux
  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      ADDR_DATA:   avs.readdata = BUS_W'(data);
      ADDR_MODE:   avs.readdata = BUS_W'(mode);
      ADDR_PERIOD: avs.readdata = BUS_W'(period);
      ADDR_PULSE:  avs.readdata = BUS_W'(pulse_active);
      ADDR_PLEN:   avs.readdata = BUS_W'(pulse_len);
      default:     avs.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_system_led_ctrl.sv
// Directed self-checking bench for nios_system_led_ctrl (WIDTH=8, PRESCALE_W=24).
module tb_nios_system_led_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;
  int         n_checks = 0;
  int         n_errors = 0;

  nios_system_led_ctrl_if bus ();

  nios_system_led_ctrl #(
    .WIDTH          (8),
    .PRESCALE_W     (24),
    .RESET_VALUE    (8'h00),
    .DEFAULT_PERIOD (24'd4999999)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus.slave),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller is at a falling edge; the write lands on the next rising edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    check(tag, bus.readdata, exp);
    bus.chipselect = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    check("rst_out", 32'(out_port), 32'h0);
    chk_rd("rst_data", 3'd0, 32'h0);
    chk_rd("rst_mode", 3'd1, 32'h0);
    chk_rd("rst_period", 3'd2, 32'd4999999);
    chk_rd("rst_plen", 3'd6, 32'h1);

    // Set / clear
    @(negedge clk);
    wr(3'd0, 32'h0F);
    wr(3'd4, 32'h30);
    wr(3'd5, 32'h03);
    chk_rd("setclr_data", 3'd0, 32'h3C);
    @(negedge clk);
    check("setclr_out", 32'(out_port), 32'h3C);
    chk_rd("rd_outset", 3'd4, 32'h0);
    chk_rd("rd_outclr", 3'd5, 32'h0);
    wr(3'd7, 32'hFFFF_FFFF);
    chk_rd("rd_rsvd", 3'd7, 32'h0);
    wr(3'd0, 32'h1FF);
    chk_rd("wide_data", 3'd0, 32'hFF);
    @(negedge clk);
    check("wide_out", 32'(out_port), 32'hFF);

    // Asynchronous reset mid-cycle
    #2 reset_n = 1'b0;
    #1 check("async_rst_out", 32'(out_port), 32'h0);
    chk_rd("async_rst_data", 3'd0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Blink: PERIOD=3 gives ticks 4 clocks apart, bit 0 toggles every 4 clocks
    wr(3'd2, 32'd3);
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h01);
    for (int k = 3; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("blink_k%0d", k), 32'(out_port), (((k - 1) / 4) % 2 == 1) ? 32'hFE : 32'hFF);
    end
    wr(3'd1, 32'h00);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("static_k%0d", k), 32'(out_port), 32'hFF);
    end

    // Pulse: PULSE_LEN=2, write one clock before the first tick
    wr(3'd2, 32'd3);
    wr(3'd6, 32'd2);
    wr(3'd0, 32'h00);
    wr(3'd3, 32'h80);
    chk_rd("pulse_rd0", 3'd3, 32'h80);
    for (int k = 4; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("pulse_out_k%0d", k), 32'(out_port), (k <= 8) ? 32'h80 : 32'h00);
      if (k == 7) chk_rd("pulse_rd7", 3'd3, 32'h80);
      if (k == 8) chk_rd("pulse_rd8", 3'd3, 32'h00);
    end

    // PULSE_LEN = 0 behaves as 1
    wr(3'd2, 32'd3);
    wr(3'd6, 32'd0);
    wr(3'd3, 32'h40);
    chk_rd("plen0_len", 3'd6, 32'h0);
    chk_rd("plen0_rd2", 3'd3, 32'h40);
    @(negedge clk);
    chk_rd("plen0_rd3", 3'd3, 32'h40);
    @(negedge clk);
    chk_rd("plen0_rd4", 3'd3, 32'h00);

    // Zero PULSE write is ignored
    wr(3'd3, 32'h00);
    chk_rd("pulse_zero", 3'd3, 32'h00);

    // Retrigger on the tick cycle: write wins, count restarts at 3
    wr(3'd2, 32'd3);
    wr(3'd6, 32'd3);
    wr(3'd3, 32'h01);
    @(negedge clk);
    wr(3'd3, 32'h02);
    chk_rd("retrig_rd4", 3'd3, 32'h03);
    repeat (11) @(negedge clk);
    chk_rd("retrig_rd15", 3'd3, 32'h03);
    @(negedge clk);
    chk_rd("retrig_rd16", 3'd3, 32'h00);

    // PERIOD write on the would-be tick cycle suppresses that tick
    do_reset();
    wr(3'd2, 32'd3);
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h01);
    @(negedge clk);
    wr(3'd2, 32'd1);
    chk_rd("pwr_period", 3'd2, 32'd1);
    for (int k = 5; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("pwr_k%0d", k), 32'(out_port), (((k - 5) / 2) % 2 == 0) ? 32'hFF : 32'hFE);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
